// File: rtl/mul_issue_ctrl.sv
// Issue/sequencing controller for the EX-stage 32x32 multiplier.
// It holds one op at a time, keeps the operands stable for LATENCY cycles, then holds the result until it is taken.
module mul_issue_ctrl #(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t           state;
  logic [3:0]       cnt;
  logic [31:0]      x_reg;
  logic [31:0]      y_reg;
  logic [TAG_W-1:0] tag_reg;
  logic             mul_signed;
  logic             use_high;
  logic             accept;
  logic             op_signed;
  logic             op_high;
  logic [65:0]      prod_full;
  logic [31:0]      prod_sel;

  assign in_ready  = ~flush & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign busy      = (state != IDLE);

  // Low half is identical for signed and unsigned, so only MULH.W multiplies signed.
  assign op_signed = (in_op == 2'b01);
  assign op_high   = (in_op == 2'b01) | (in_op == 2'b10);

  // Multicycle path: operand registers feed the tree and stay put for the whole CALC phase.
  assign prod_full = 66'($signed({mul_signed & x_reg[31], x_reg}) *
                         $signed({mul_signed & y_reg[31], y_reg}));
  assign prod_sel  = use_high ? prod_full[63:32] : prod_full[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_tag    <= '0;
      x_reg      <= 32'd0;
      y_reg      <= 32'd0;
      tag_reg    <= '0;
      mul_signed <= 1'b0;
      use_high   <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        x_reg      <= in_x;
        y_reg      <= in_y;
        tag_reg    <= in_tag;
        mul_signed <= op_signed;
        use_high   <= op_high;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= CALC;
            cnt   <= CNT_INIT;
          end
        end
        CALC: begin
          if (cnt == 4'd0) begin
            out_result <= prod_sel;
            out_tag    <= tag_reg;
            out_valid  <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              state <= CALC;
              cnt   <= CNT_INIT;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= 4'd0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: product halves, latency, backpressure, back-to-back issue and flush.
module tb_mul_issue_ctrl;

  localparam int LATENCY = 2;
  localparam int TAG_W   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_x;
  logic [31:0]      in_y;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int compareCount  = 0;
  int mismatchCount = 0;

  mul_issue_ctrl #(.LATENCY(LATENCY), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_x       (in_x),
    .in_y       (in_y),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                               input logic [TAG_W-1:0] tag, input logic valid, input logic ready);
    in_op     = op;
    in_x      = x;
    in_y      = y;
    in_tag    = tag;
    in_valid  = valid;
    out_ready = ready;
    #1;
  endtask

  // Counts cycles after the accept edge until out_valid, bounded.
  task automatic waitResult(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      waitCycle();
      n++;
    end
  endtask

  // Issues one op from IDLE with out_ready high, checks latency, result and tag, then the drain to IDLE.
  task automatic issueAndCheck(input string name, input logic [1:0] op, input logic [31:0] x,
                               input logic [31:0] y, input logic [TAG_W-1:0] tag, input logic [31:0] expected);
    int n;
    applyStimulus(op, x, y, tag, 1'b1, 1'b1);
    checkOutput({name, "_in_ready"}, 64'(in_ready), 64'd1);
    waitCycle();
    in_valid = 1'b0;
    waitResult(n);
    checkOutput({name, "_latency"}, 64'(n), 64'(LATENCY));
    checkOutput({name, "_result"}, 64'(out_result), 64'(expected));
    checkOutput({name, "_tag"}, 64'(out_tag), 64'(tag));
    waitCycle();
    checkOutput({name, "_drained"}, 64'({out_valid, busy}), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] heldResult;
    logic [TAG_W-1:0] heldTag;
    logic sawValid;

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_op = 2'b00;
    in_x = 32'd0;
    in_y = 32'd0;
    in_tag = '0;
    out_ready = 1'b0;
    waitCycle();
    waitCycle();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_result", 64'(out_result), 64'd0);
    checkOutput("reset_out_tag", 64'(out_tag), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] product halves");
    issueAndCheck("mulw_7x6", 2'b00, 32'd7, 32'd6, 5'd1, 32'd42);
    issueAndCheck("mulhw_min", 2'b01, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
    issueAndCheck("mulhwu_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFE);
    issueAndCheck("mulw_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0001);
    issueAndCheck("mulhw_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 5'd7, 32'hFFFF_FFFF);
    issueAndCheck("mulw_neg", 2'b00, 32'hFFFF_FFFD, 32'd5, 5'd8, 32'hFFFF_FFF1);
    issueAndCheck("op11_max", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001);
    issueAndCheck("mulhwu_mix", 2'b10, 32'h8000_0000, 32'd6, 5'd10, 32'h0000_0003);

    $display("[TB] backpressure");
    applyStimulus(2'b00, 32'd100, 32'd3, 5'd11, 1'b1, 1'b0);
    waitCycle();
    in_valid = 1'b0;
    waitResult(n);
    checkOutput("bp_latency", 64'(n), 64'(LATENCY));
    heldResult = out_result;
    heldTag = out_tag;
    checkOutput("bp_result", 64'(heldResult), 64'd300);
    applyStimulus(2'b01, 32'd1, 32'd1, 5'd12, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_in_ready", 64'(in_ready), 64'd0);
      waitCycle();
      checkOutput("bp_hold", 64'({out_valid, out_result, out_tag}), 64'({1'b1, 32'd300, 5'd11}));
    end
    applyStimulus(2'b00, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
    waitCycle();
    checkOutput("bp_released", 64'({out_valid, busy}), 64'd0);

    $display("[TB] back-to-back");
    applyStimulus(2'b00, 32'd9, 32'd9, 5'd3, 1'b1, 1'b1);
    waitCycle();
    in_valid = 1'b0;
    waitResult(n);
    checkOutput("b2b_first_tag", 64'(out_tag), 64'd3);
    checkOutput("b2b_first_result", 64'(out_result), 64'd81);
    applyStimulus(2'b00, 32'd12, 32'd12, 5'd4, 1'b1, 1'b1);
    checkOutput("b2b_in_ready", 64'(in_ready), 64'd1);
    waitCycle();
    in_valid = 1'b0;
    checkOutput("b2b_busy", 64'({busy, out_valid}), 64'b10);
    waitResult(n);
    checkOutput("b2b_second_latency", 64'(n), 64'(LATENCY));
    checkOutput("b2b_second_tag", 64'(out_tag), 64'd4);
    checkOutput("b2b_second_result", 64'(out_result), 64'd144);
    waitCycle();
    checkOutput("b2b_drained", 64'({out_valid, busy}), 64'd0);

    $display("[TB] flush");
    applyStimulus(2'b00, 32'd2, 32'd2, 5'd13, 1'b1, 1'b1);
    waitCycle();
    in_valid = 1'b0;
    flush = 1'b1;
    waitCycle();
    flush = 1'b0;
    #1;
    checkOutput("flush_busy", 64'(busy), 64'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sawValid = sawValid | out_valid;
      waitCycle();
    end
    checkOutput("flush_no_valid", 64'(sawValid | out_valid), 64'd0);
    checkOutput("flush_result_kept", 64'(out_result), 64'd144);
    applyStimulus(2'b00, 32'd5, 32'd5, 5'd14, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("flush_in_ready", 64'(in_ready), 64'd0);
    waitCycle();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    checkOutput("flush_no_accept", 64'(busy), 64'd0);
    issueAndCheck("post_flush", 2'b00, 32'd11, 32'd3, 5'd15, 32'd33);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
